// File: rtl/bitrev_obi_buf.sv
// OBI-attached bit-reversal reorder buffer: frames of 2^K words are written in
// natural order to bit-reversed SRAM addresses and read back sequentially.
module bitrev_obi_buf #(
   parameter int K       = 10,
   parameter int DW      = 32,
   parameter int IdWidth = 1
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               obi_req_i,
   output logic               obi_gnt_o,
   input  logic [31:0]        obi_addr_i,
   input  logic               obi_we_i,
   input  logic [3:0]         obi_be_i,
   input  logic [31:0]        obi_wdata_i,
   input  logic [IdWidth-1:0] obi_aid_i,
   output logic               obi_rvalid_o,
   output logic [31:0]        obi_rdata_o,
   output logic [IdWidth-1:0] obi_rid_o,
   output logic               obi_err_o,
   output logic               sram_req_o,
   output logic               sram_we_o,
   output logic [K-1:0]       sram_addr_o,
   output logic [DW-1:0]      sram_wdata_o,
   input  logic [DW-1:0]      sram_rdata_i
);

   typedef enum logic {IDLE, RESP} state_t;

   localparam logic [K:0] FULL_CNT = {1'b1, {K{1'b0}}};

   state_t             r_state;
   logic [K:0]         r_wr_cnt;
   logic [K-1:0]       r_rd_idx;
   logic               r_rvalid;
   logic               r_err;
   logic [31:0]        r_rdata;
   logic [IdWidth-1:0] r_rid;
   logic               r_rd_sram;

   logic               w_gnt;
   logic               w_full;
   logic [K-1:0]       w_rev;
   logic [9:0]         w_sel;
   logic               w_err;
   logic [31:0]        w_rdata;
   logic               w_wr_ok;
   logic               w_rd_ok;
   logic               w_clear;
   logic [31:0]        w_status;
   logic               w_unused;

   // Byte enables and out-of-window address bits carry no meaning here.
   assign w_unused = ^{obi_be_i, obi_addr_i[31:12], obi_addr_i[1:0]};

   assign w_full   = (r_wr_cnt == FULL_CNT);
   assign w_sel    = obi_addr_i[11:2];
   assign w_gnt    = obi_req_i & (r_state == IDLE) & ~rst_i;
   assign w_status = {16'(r_wr_cnt), 15'd0, w_full};

   for (genvar gi = 0; gi < K; gi++) begin : g_rev
      assign w_rev[gi] = r_wr_cnt[K-1-gi];
   end

   always_comb begin
      w_err   = 1'b1;
      w_rdata = 32'd0;
      w_wr_ok = 1'b0;
      w_rd_ok = 1'b0;
      w_clear = 1'b0;
      case (w_sel)
         10'd0: begin
            w_err   = 1'b0;
            w_clear = obi_we_i & obi_wdata_i[0];
         end
         10'd1: begin
            w_err = 1'b0;
            if (!obi_we_i) w_rdata = w_status;
         end
         10'd2: begin
            if (obi_we_i) begin
               w_err   = w_full;
               w_wr_ok = ~w_full;
            end else begin
               w_err = 1'b0;
            end
         end
         10'd3: begin
            if (!obi_we_i && w_full) begin
               w_err   = 1'b0;
               w_rd_ok = 1'b1;
            end
         end
         default: w_err = 1'b1;
      endcase
   end

   assign obi_gnt_o    = w_gnt;
   assign sram_req_o   = w_gnt & (w_wr_ok | w_rd_ok);
   assign sram_we_o    = w_gnt & w_wr_ok;
   assign sram_addr_o  = w_wr_ok ? w_rev : r_rd_idx;
   assign sram_wdata_o = obi_wdata_i;

   // SRAM read data arrives in the response cycle, so it bypasses r_rdata.
   assign obi_rvalid_o = r_rvalid;
   assign obi_err_o    = r_err;
   assign obi_rid_o    = r_rid;
   assign obi_rdata_o  = r_rd_sram ? sram_rdata_i : r_rdata;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state   <= IDLE;
         r_wr_cnt  <= '0;
         r_rd_idx  <= '0;
         r_rvalid  <= 1'b0;
         r_err     <= 1'b0;
         r_rdata   <= 32'd0;
         r_rid     <= '0;
         r_rd_sram <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_gnt) begin
                  r_state   <= RESP;
                  r_rvalid  <= 1'b1;
                  r_err     <= w_err;
                  r_rdata   <= w_rdata;
                  r_rid     <= obi_aid_i;
                  r_rd_sram <= w_rd_ok;
                  if (w_clear) begin
                     r_wr_cnt <= '0;
                     r_rd_idx <= '0;
                  end
                  if (w_wr_ok) r_wr_cnt <= r_wr_cnt + (K+1)'(1);
                  if (w_rd_ok) r_rd_idx <= r_rd_idx + K'(1);
               end
            end
            RESP: begin
               r_state   <= IDLE;
               r_rvalid  <= 1'b0;
               r_err     <= 1'b0;
               r_rdata   <= 32'd0;
               r_rd_sram <= 1'b0;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_bitrev_obi_buf.sv
// Directed bench for bitrev_obi_buf at K=3 with a response scoreboard, an
// SRAM-access scoreboard and a behavioural single-port SRAM.
module tb_bitrev_obi_buf;

   localparam int K   = 3;
   localparam int DW  = 32;
   localparam int IDW = 1;

   typedef struct packed {
      logic [31:0]    rdata;
      logic           err;
      logic [IDW-1:0] id;
   } resp_t;

   typedef struct packed {
      logic         we;
      logic [K-1:0] addr;
   } sacc_t;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic           req = 1'b0;
   logic           gnt;
   logic [31:0]    addr = 32'd0;
   logic           we = 1'b0;
   logic [3:0]     be = 4'hF;
   logic [31:0]    wdata = 32'd0;
   logic [IDW-1:0] aid = '0;
   logic           rvalid;
   logic [31:0]    rdata;
   logic [IDW-1:0] rid;
   logic           err;
   logic           sram_req;
   logic           sram_we;
   logic [K-1:0]   sram_addr;
   logic [DW-1:0]  sram_wdata;
   logic [DW-1:0]  sram_rdata = '0;

   logic [DW-1:0]  mem [0:(1<<K)-1];

   resp_t sb_q[$];
   sacc_t sram_q[$];
   int    n_checks = 0;
   int    n_fail   = 0;
   logic  mon_en   = 1'b0;

   bitrev_obi_buf #(.K(K), .DW(DW), .IdWidth(IDW)) dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .obi_req_i    (req),
      .obi_gnt_o    (gnt),
      .obi_addr_i   (addr),
      .obi_we_i     (we),
      .obi_be_i     (be),
      .obi_wdata_i  (wdata),
      .obi_aid_i    (aid),
      .obi_rvalid_o (rvalid),
      .obi_rdata_o  (rdata),
      .obi_rid_o    (rid),
      .obi_err_o    (err),
      .sram_req_o   (sram_req),
      .sram_we_o    (sram_we),
      .sram_addr_o  (sram_addr),
      .sram_wdata_o (sram_wdata),
      .sram_rdata_i (sram_rdata)
   );

   initial forever #5 clk = ~clk;

   always @(posedge clk) begin
      if (sram_req) begin
         if (sram_we) mem[sram_addr] <= sram_wdata;
         else         sram_rdata     <= mem[sram_addr];
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   // Response and SRAM monitor, sampling on the falling edge.
   initial begin
      logic  gnt_prev;
      resp_t r;
      sacc_t s;
      gnt_prev = 1'b0;
      forever begin
         @(negedge clk);
         if (mon_en) begin
            check("rvalid_timing", 32'(rvalid), 32'(gnt_prev));
            if (rvalid) begin
               check("rsp_expected", 32'(sb_q.size() != 0), 32'd1);
               if (sb_q.size() != 0) begin
                  r = sb_q.pop_front();
                  check("rsp_rdata", rdata, r.rdata);
                  check("rsp_err", 32'(err), 32'(r.err));
                  check("rsp_rid", 32'(rid), 32'(r.id));
                  $display("rsp rdata=0x%08h err=%0d rid=%0d", rdata, err, rid);
               end
            end
            if (sram_req) begin
               check("sram_expected", 32'(sram_q.size() != 0), 32'd1);
               if (sram_q.size() != 0) begin
                  s = sram_q.pop_front();
                  check("sram_we", 32'(sram_we), 32'(s.we));
                  check("sram_addr", 32'(sram_addr), 32'(s.addr));
               end
            end
            gnt_prev = gnt;
         end
      end
   end

   // Issues one access, waits (bounded) for the grant and queues the response.
   task automatic do_acc(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [IDW-1:0] id, input logic [31:0] exp_rd,
                         input logic exp_err);
      logic got;
      got = 1'b0;
      @(posedge clk); #1;
      req = 1'b1; we = w; addr = a; wdata = d; aid = id;
      for (int t = 0; t < 20 && !got; t++) begin
         @(negedge clk);
         if (gnt) got = 1'b1;
      end
      check("gnt_seen", 32'(got), 32'd1);
      if (got) sb_q.push_back('{rdata: exp_rd, err: exp_err, id: id});
      @(posedge clk); #1;
      req = 1'b0;
      $display("acc we=%0d addr=0x%03h wdata=0x%08h aid=%0d", w, a, d, id);
   endtask

   initial begin
      logic [K-1:0] wr_tab [0:7];
      logic [31:0]  rd_tab [0:8];
      logic [3:0]   gpat;
      wr_tab = '{3'd0, 3'd4, 3'd2, 3'd6, 3'd1, 3'd5, 3'd3, 3'd7};
      rd_tab = '{32'd0, 32'd4, 32'd2, 32'd6, 32'd1, 32'd5, 32'd3, 32'd7, 32'd0};

      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_rvalid", 32'(rvalid), 32'd0);
      check("rst_err", 32'(err), 32'd0);
      check("rst_rdata", rdata, 32'd0);
      check("rst_rid", 32'(rid), 32'd0);
      check("rst_sram_req", 32'(sram_req), 32'd0);
      mon_en = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;

      do_acc(1'b0, 32'h004, 32'd0, 1'b0, 32'd0, 1'b0);

      // Fill one frame: natural-order writes land at bit-reversed addresses.
      for (int i = 0; i < 8; i++) begin
         sram_q.push_back('{we: 1'b1, addr: wr_tab[i]});
         do_acc(1'b1, 32'h008, 32'(i), IDW'(i), 32'd0, 1'b0);
      end
      do_acc(1'b0, 32'h004, 32'd0, 1'b1, 32'h0008_0001, 1'b0);

      do_acc(1'b1, 32'h008, 32'hDEAD, 1'b0, 32'd0, 1'b1);
      do_acc(1'b0, 32'h004, 32'd0, 1'b0, 32'h0008_0001, 1'b0);

      // Nine reads: the ninth wraps and re-reads the frame start.
      for (int i = 0; i < 9; i++) begin
         sram_q.push_back('{we: 1'b0, addr: K'(i)});
         do_acc(1'b0, 32'h00C, 32'd0, IDW'(i), rd_tab[i], 1'b0);
      end

      do_acc(1'b1, 32'h00C, 32'h1234, 1'b1, 32'd0, 1'b1);
      do_acc(1'b0, 32'h008, 32'd0, 1'b0, 32'd0, 1'b0);
      do_acc(1'b0, 32'h000, 32'd0, 1'b1, 32'd0, 1'b0);
      do_acc(1'b1, 32'h004, 32'hFFFF_FFFF, 1'b0, 32'd0, 1'b0);
      do_acc(1'b0, 32'h004, 32'd0, 1'b0, 32'h0008_0001, 1'b0);

      do_acc(1'b1, 32'h000, 32'd1, 1'b1, 32'd0, 1'b0);
      do_acc(1'b0, 32'h004, 32'd0, 1'b0, 32'd0, 1'b0);
      do_acc(1'b0, 32'h00C, 32'd0, 1'b1, 32'd0, 1'b1);

      // Request held high: grants alternate with response cycles.
      @(posedge clk); #1;
      req = 1'b1; we = 1'b0; addr = 32'h004; aid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         gpat[i] = gnt;
         if (gnt) sb_q.push_back('{rdata: 32'd0, err: 1'b0, id: aid});
         @(posedge clk); #1;
         aid = ~aid;
      end
      req = 1'b0;
      check("gnt_pattern", 32'(gpat), 32'h5);
      $display("gnt pattern (i=3..0) = %b", gpat);

      do_acc(1'b0, 32'h010, 32'd0, 1'b1, 32'd0, 1'b1);
      do_acc(1'b1, 32'h010, 32'h55, 1'b0, 32'd0, 1'b1);
      do_acc(1'b0, 32'hFFC, 32'd0, 1'b1, 32'd0, 1'b1);

      // Three writes, then reset lands in the third write's response cycle.
      for (int i = 0; i < 3; i++) begin
         sram_q.push_back('{we: 1'b1, addr: wr_tab[i]});
         do_acc(1'b1, 32'h008, 32'hA0 + 32'(i), 1'b1, 32'd0, 1'b0);
      end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      do_acc(1'b0, 32'h004, 32'd0, 1'b0, 32'd0, 1'b0);

      // Reset wins over a simultaneous request.
      @(posedge clk); #1;
      rst = 1'b1; req = 1'b1; we = 1'b1; addr = 32'h008; wdata = 32'h77;
      @(negedge clk);
      check("gnt_in_reset", 32'(gnt), 32'd0);
      check("sram_in_reset", 32'(sram_req), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0; req = 1'b0;
      do_acc(1'b0, 32'h004, 32'd0, 1'b1, 32'd0, 1'b0);

      repeat (3) @(posedge clk);
      #1;
      check("sb_drained", 32'(sb_q.size()), 32'd0);
      check("sram_drained", 32'(sram_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/bitrev_obi_buf.md
BITREV_OBI_BUF -- requirements
Module: bitrev_obi_buf

Interface
REQ-001 SHALL have parameter K, default 10 (BITREV_K): log2 of the frame length, 2^K words per frame.
REQ-002 SHALL have parameter DW, default 32 (BITREV_DW): data word width; the OBI data width is fixed at 32, and DW SHALL equal 32.
REQ-003 SHALL have parameter IdWidth, default 1: OBI aid/rid width.
REQ-004 clk_i  in  1  single clock; all state updates on its rising edge.
REQ-005 rst_i  in  1  reset, synchronous and active-high.
REQ-006 obi_req_i  in  1  OBI request.
REQ-007 obi_gnt_o  out  1  OBI grant.
REQ-008 obi_addr_i  in  32  byte address; only bits [11:2] are decoded inside the 4 KiB UserBitrev window.
REQ-009 obi_we_i  in  1  write enable.
REQ-010 obi_be_i  in  4  byte enables; ignored, every access is a full word.
REQ-011 obi_wdata_i  in  32  write data.
REQ-012 obi_aid_i  in  IdWidth  transaction ID.
REQ-013 obi_rvalid_o  out  1  response valid.
REQ-014 obi_rdata_o  out  32  read data.
REQ-015 obi_rid_o  out  IdWidth  response ID, equal to the aid of the granted request.
REQ-016 obi_err_o  out  1  response error, qualified by rvalid.
REQ-017 sram_req_o / sram_we_o / sram_addr_o[K-1:0] / sram_wdata_o[DW-1:0]  out  SRAM port to a single-port, 1-cycle-read-latency macro of 2^K words.
REQ-018 sram_rdata_i  in  DW  SRAM read data, valid the cycle after the read request.

Function
REQ-019 SHALL implement FSM states IDLE and RESP; IDLE->RESP on grant; RESP->IDLE unconditionally.
REQ-020 obi_gnt_o SHALL equal obi_req_i while in IDLE and SHALL be 0 in RESP; the maximum rate is therefore one access per 2 cycles.
REQ-021 obi_rvalid_o SHALL be 1 exactly in the RESP cycle, i.e. one cycle after the grant, for every access type.
REQ-022 Register map by addr[11:0]:
- 0x00 CTRL
- 0x04 STATUS
- 0x08 DATA_IN
- 0x0C DATA_OUT
REQ-023 Any other offset SHALL respond with err=1 and rdata=0, and SHALL have no side effect.
REQ-024 State: wr_cnt (K+1 bits, 0..2^K), rd_idx (K bits), full = (wr_cnt == 2^K).
REQ-025 CTRL write with wdata[0]=1 SHALL clear wr_cnt and rd_idx to 0 at the grant edge; a CTRL read SHALL return 0; err=0 in both cases.
REQ-026 STATUS read SHALL return bit0=full, bits[31:16]=wr_cnt zero-extended, all other bits 0; STATUS write SHALL be ignored with err=0.
REQ-027 DATA_IN write with !full SHALL issue sram_req_o=1, sram_we_o=1, sram_addr_o=bit-reverse of wr_cnt[K-1:0] (bit i -> bit K-1-i) and sram_wdata_o=wdata in the grant cycle, and SHALL increment wr_cnt.
REQ-028 DATA_IN write with full SHALL not touch the SRAM and SHALL respond err=1; DATA_IN read SHALL return 0 with err=0.
REQ-029 DATA_OUT read with full SHALL issue an SRAM read at rd_idx in the grant cycle, return sram_rdata_i as rdata in RESP, and set rd_idx <= rd_idx+1 mod 2^K; a wrap to 0 SHALL keep full asserted so the frame can be re-read.
REQ-030 DATA_OUT read with !full SHALL respond err=1 and rdata=0, with no SRAM access; a DATA_OUT write SHALL respond err=1.
REQ-031 sram_req_o SHALL be 0 in every cycle except the grant cycles of REQ-027 and REQ-029.
REQ-032 rdata SHALL be 0 on all write responses and on all error responses.

Reset
REQ-033 On rst_i=1 at a clock edge:
- FSM -> IDLE
- wr_cnt=0, rd_idx=0
- obi_rvalid_o=0, obi_err_o=0, obi_rdata_o=0, obi_rid_o=0
- sram_req_o=0
REQ-034 A response pending during reset SHALL be dropped; SRAM contents are not cleared.
REQ-035 Reset SHALL take priority over a simultaneous grant; that request is not granted.

Verification (K=3)
REQ-036 Write 0..7 to DATA_IN -> SRAM write addresses 0,4,2,6,1,5,3,7; STATUS=0x0008_0001.
REQ-037 After REQ-036, read DATA_OUT 9 times -> rdata 0,4,2,6,1,5,3,7,0, all err=0, rvalid 1 cycle after each gnt.
REQ-038 Full frame, write DATA_IN -> err=1, no SRAM access, STATUS unchanged; then CTRL=1 -> STATUS=0, DATA_OUT read -> err=1, rdata=0.
REQ-039 req held high continuously -> gnt pattern 1,0,1,0; access to 0x010 -> err=1; rid echoes aid.
REQ-040 rst_i asserted in a RESP cycle after 3 DATA_IN writes -> rvalid=0 the next cycle, STATUS=0.
